// File: rtl/seg7_result_display.sv
// seg7_result_display
//   Captures the last write-back result and the last store data from the
//   pipelined core and shows the selected 32-bit word as hex on a
//   time-multiplexed, common-anode 7-segment bank. The digit-0 decimal point
//   flashes for FLASH_CYCLES clocks after each new capture of the selected
//   source.
// Ports
//   clk            core clock
//   rst            synchronous, active-high reset
//   ResultW_in     write-back result        RegWriteW_in  write-back strobe
//   WriteDataM_in  store data               MemWriteM_in  store strobe
//   disp_sel       0 = last result, 1 = last store data
//   freeze         1 = block captures (scanning continues)
//   seg            {g,f,e,d,c,b,a}, active-low, registered
//   dp             decimal point, active-low, registered
//   an             digit enables, active-low, exactly one low, registered
module seg7_result_display #(
  parameter int unsigned DIGITS       = 8,
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned FLASH_CYCLES = 5000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       ResultW_in,
  input  logic              RegWriteW_in,
  input  logic [31:0]       WriteDataM_in,
  input  logic              MemWriteM_in,
  input  logic              disp_sel,
  input  logic              freeze,
  output logic [6:0]        seg,
  output logic              dp,
  output logic [DIGITS-1:0] an
);

  localparam int unsigned PW = $clog2(REFRESH_DIV);
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned FW = $clog2(FLASH_CYCLES + 1);

  logic [31:0]       res_q, res_d;
  logic [31:0]       st_q, st_d;
  logic [PW-1:0]     pre_q, pre_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [FW-1:0]     flash_q, flash_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic [DIGITS-1:0] an_q, an_d;

  logic        cap_res, cap_st, sel_cap;
  logic [31:0] word;
  logic [3:0]  nib;
  logic [6:0]  code;

  always_comb begin
    cap_res = RegWriteW_in & ~freeze;
    cap_st  = MemWriteM_in & ~freeze;
    res_d   = cap_res ? ResultW_in : res_q;
    st_d    = cap_st ? WriteDataM_in : st_q;

    // Digit scan: the index only moves on the prescaler wrap edge.
    pre_d = pre_q + PW'(1);
    idx_d = idx_q;
    if (pre_q == PW'(REFRESH_DIV - 1)) begin
      pre_d = '0;
      idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end

    // Flash restarts only on a capture of the source currently on display.
    sel_cap = disp_sel ? cap_st : cap_res;
    flash_d = flash_q;
    if (sel_cap)
      flash_d = FW'(FLASH_CYCLES);
    else if (flash_q != '0)
      flash_d = flash_q - FW'(1);

    word = disp_sel ? st_q : res_q;
    nib  = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i))
        nib = word[4*i +: 4];
    end

    unique case (nib)
      4'h0: code = 7'h3F;
      4'h1: code = 7'h06;
      4'h2: code = 7'h5B;
      4'h3: code = 7'h4F;
      4'h4: code = 7'h66;
      4'h5: code = 7'h6D;
      4'h6: code = 7'h7D;
      4'h7: code = 7'h07;
      4'h8: code = 7'h7F;
      4'h9: code = 7'h6F;
      4'hA: code = 7'h77;
      4'hB: code = 7'h7C;
      4'hC: code = 7'h39;
      4'hD: code = 7'h5E;
      4'hE: code = 7'h79;
      default: code = 7'h71;
    endcase

    seg_d = ~code;
    an_d  = ~(DIGITS'(1) << idx_q);
    dp_d  = ~((idx_q == '0) && (flash_q != '0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q   <= '0;
      st_q    <= '0;
      pre_q   <= '0;
      idx_q   <= '0;
      flash_q <= '0;
      seg_q   <= 7'b1000000;
      dp_q    <= 1'b1;
      an_q    <= ~DIGITS'(1);
    end else begin
      res_q   <= res_d;
      st_q    <= st_d;
      pre_q   <= pre_d;
      idx_q   <= idx_d;
      flash_q <= flash_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;

endmodule

// File: tb/tb_seg7_result_display.sv
// Testbench for seg7_result_display (DIGITS=8, REFRESH_DIV=4, FLASH_CYCLES=6).
// Stimulus pushes cycle-stamped expectations into a sorted queue; a monitor
// on the falling edge pops and compares them against the registered outputs.
module tb_seg7_result_display;

  logic        clk;
  logic        rst;
  logic [31:0] ResultW_in;
  logic        RegWriteW_in;
  logic [31:0] WriteDataM_in;
  logic        MemWriteM_in;
  logic        disp_sel;
  logic        freeze;
  logic [6:0]  seg;
  logic        dp;
  logic [7:0]  an;

  seg7_result_display #(
    .DIGITS      (8),
    .REFRESH_DIV (4),
    .FLASH_CYCLES(6)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ResultW_in   (ResultW_in),
    .RegWriteW_in (RegWriteW_in),
    .WriteDataM_in(WriteDataM_in),
    .MemWriteM_in (MemWriteM_in),
    .disp_sel     (disp_sel),
    .freeze       (freeze),
    .seg          (seg),
    .dp           (dp),
    .an           (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Number of rising edges seen so far; stable when read on falling edges.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Cycle-relative origin: j=0 is the last edge of the initial reset.
  localparam int BASE = 3;

  localparam logic [6:0] CODE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef struct {
    int         cyc;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void push_exp(int c, logic [7:0] a, logic [6:0] s, logic d, string nm);
    exp_t e;
    int unsigned i;
    e.cyc = c; e.an = a; e.seg = s; e.dp = d; e.nm = nm;
    i = 0;
    while (i < q.size() && q[i].cyc <= c) i++;
    q.insert(i, e);
  endfunction

  // Expect digit d showing nibble d of word w after relative edge j.
  function automatic void exp_digit(int j, int d, logic [31:0] w, logic dpv, string nm);
    logic [7:0] one;
    logic [3:0] n;
    one = 8'b1;
    n   = w[4*d +: 4];
    push_exp(BASE + j, ~(one << d), ~CODE[n], dpv, nm);
  endfunction

  // Returns on the falling edge after relative edge j; inputs set then are
  // sampled at edge j+1.
  task automatic go(int j);
    while (cyc < BASE + j) @(negedge clk);
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      mon_e = q.pop_front();
      checks++;
      if (mon_e.cyc < cyc) begin
        errors++;
        $display("FAIL %s: check for cycle %0d not reached (now %0d)", mon_e.nm, mon_e.cyc, cyc);
      end else if (an !== mon_e.an || seg !== mon_e.seg || dp !== mon_e.dp) begin
        errors++;
        $display("FAIL %s @cyc %0d: got an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b",
                 mon_e.nm, cyc, an, seg, dp, mon_e.an, mon_e.seg, mon_e.dp);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; ResultW_in = '0; RegWriteW_in = 1'b0; WriteDataM_in = '0;
    MemWriteM_in = 1'b0; disp_sel = 1'b0; freeze = 1'b0;

    // 1: reset for 3 edges, then a full scan plus wrap with an all-zero word.
    for (int j = -2; j <= 0; j++) exp_digit(j, 0, 32'h0, 1'b1, "reset");
    go(0);
    rst = 1'b0;
    for (int j = 1; j <= 36; j++) exp_digit(j, ((j - 1) / 4) % 8, 32'h0, 1'b1, "scan");

    // 2: result capture at edge 40 (digit 1 active, so no visible flash).
    go(39);
    RegWriteW_in = 1'b1; ResultW_in = 32'h1234ABCD;
    exp_digit(40, 1, 32'h0, 1'b1, "cap_edge");
    exp_digit(41, 2, 32'h1234ABCD, 1'b1, "cap_plus1");
    for (int d = 0; d < 8; d++) exp_digit(66 + 4*d, d, 32'h1234ABCD, 1'b1, "res_digit");
    go(40);
    RegWriteW_in = 1'b0;

    // 3: simultaneous strobes at edge 104, then select the store word.
    go(103);
    MemWriteM_in = 1'b1; WriteDataM_in = 32'hFFFF0000;
    RegWriteW_in = 1'b1; ResultW_in = 32'h0;
    exp_digit(104, 1, 32'h1234ABCD, 1'b1, "both_edge");
    exp_digit(105, 2, 32'h0, 1'b1, "both_res");
    for (int d = 0; d < 8; d++) exp_digit(130 + 4*d, d, 32'h0, 1'b1, "sel0_zero");
    exp_digit(177, 4, 32'h0, 1'b1, "sel_before");
    exp_digit(178, 4, 32'hFFFF0000, 1'b1, "sel_after");
    for (int d = 0; d < 8; d++) exp_digit(194 + 4*d, d, 32'hFFFF0000, 1'b1, "sel1_store");
    go(104);
    MemWriteM_in = 1'b0; RegWriteW_in = 1'b0;
    go(177);
    disp_sel = 1'b1;

    // 5: flash on selected-source capture while digit 0 is active.
    go(224);
    MemWriteM_in = 1'b1;
    exp_digit(225, 0, 32'h0, 1'b1, "flash_pre");
    for (int j = 226; j <= 228; j++) exp_digit(j, 0, 32'h0, 1'b0, "flash_on");
    exp_digit(229, 1, 32'h0, 1'b1, "flash_gate");
    go(225);
    MemWriteM_in = 1'b0;

    // Captures at 251 and 253: restarted count reaches into digit 0 for 3 cycles.
    go(250);
    MemWriteM_in = 1'b1;
    exp_digit(256, 7, 32'hFFFF0000, 1'b1, "restart_d7");
    for (int j = 257; j <= 259; j++) exp_digit(j, 0, 32'h0, 1'b0, "restart_on");
    exp_digit(260, 0, 32'h0, 1'b1, "restart_end");
    exp_digit(261, 1, 32'h0, 1'b1, "restart_d1");
    go(251);
    MemWriteM_in = 1'b0;
    go(252);
    MemWriteM_in = 1'b1;
    go(253);
    MemWriteM_in = 1'b0;

    // Capture on the unselected source: no flash.
    go(288);
    RegWriteW_in = 1'b1; ResultW_in = 32'h0;
    for (int j = 290; j <= 292; j++) exp_digit(j, 0, 32'h0, 1'b1, "unsel_noflash");
    go(289);
    RegWriteW_in = 1'b0;

    // 4: freeze blocks the capture and the flash.
    go(299);
    disp_sel = 1'b0;
    go(315);
    freeze = 1'b1;
    go(320);
    RegWriteW_in = 1'b1; ResultW_in = 32'hDEADBEEF;
    exp_digit(323, 0, 32'h0, 1'b1, "frz_dp");
    exp_digit(324, 0, 32'h0, 1'b1, "frz_dp");
    for (int d = 0; d < 8; d++) exp_digit(322 + 4*d, d, 32'h0, 1'b1, "frz_hold");
    go(321);
    RegWriteW_in = 1'b0;
    go(329);
    freeze = 1'b0;
    go(352);
    RegWriteW_in = 1'b1;
    exp_digit(353, 0, 32'h0, 1'b1, "unfrz_edge");
    for (int j = 354; j <= 356; j++) exp_digit(j, 0, 32'hDEADBEEF, 1'b0, "unfrz_flash");
    exp_digit(357, 1, 32'hDEADBEEF, 1'b1, "unfrz_d1");
    for (int d = 0; d < 8; d++) exp_digit(386 + 4*d, d, 32'hDEADBEEF, 1'b1, "unfrz_digit");
    go(353);
    RegWriteW_in = 1'b0;

    // 6: reset at idx=5 with the flash freshly loaded.
    go(435);
    RegWriteW_in = 1'b1;
    exp_digit(436, 4, 32'hDEADBEEF, 1'b1, "prerst");
    exp_digit(437, 0, 32'h0, 1'b1, "rst_mid");
    for (int j = 438; j <= 441; j++) exp_digit(j, 0, 32'h0, 1'b1, "post_rst_d0");
    for (int d = 1; d < 8; d++) exp_digit(439 + 4*d, d, 32'h0, 1'b1, "post_rst_scan");
    go(436);
    RegWriteW_in = 1'b0; rst = 1'b1;
    go(437);
    rst = 1'b0;

    go(472);
    @(negedge clk);
    while (q.size() > 0) begin
      mon_e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: check for cycle %0d never evaluated", mon_e.nm, mon_e.cyc);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
